// File: rtl/md_pkg.sv
// md_pkg: op codes, default latencies, FSM states and decode helpers for md_sched (MD_SCHED_MADD_EN enables ops 7-10)
package md_pkg;
  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  typedef enum logic {S_IDLE, S_RUN} state_t;
  function automatic logic is_div(input logic [3:0] op);
    return op == OP_DIV || op == OP_DIVU;
  endfunction
  function automatic logic is_madd(input logic [3:0] op);
    return op >= OP_MADD && op <= OP_MSUBU;
  endfunction
  function automatic logic is_muldiv(input logic [3:0] op);
`ifdef MD_SCHED_MADD_EN
    return (op >= OP_MULT && op <= OP_DIVU) || is_madd(op);
`else
    return op >= OP_MULT && op <= OP_DIVU;
`endif
  endfunction
  function automatic logic is_mt(input logic [3:0] op);
    return op == OP_MTHI || op == OP_MTLO;
  endfunction
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational 64-bit mult/div (and madd family under MD_SCHED_MADD_EN) result with divide-by-zero flag
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        div_zero
);
  logic [63:0] sprod, uprod, acc, madd;
  logic [31:0] a, b, uq, ur, q, r;
  logic        sgn;
  always_comb begin
    sprod = {{32{d1[31]}}, d1} * {{32{d2[31]}}, d2};
    uprod = {32'd0, d1} * {32'd0, d2};
    acc = {hi, lo};
    sgn = op == OP_DIV;
    // divide magnitudes, then restore signs: avoids the min/-1 overflow case
    a = sgn && d1[31] ? -d1 : d1;
    b = sgn && d2[31] ? -d2 : d2;
    div_zero = is_div(op) && d2 == 32'd0;
    uq = div_zero ? 32'd0 : a / b;
    ur = div_zero ? 32'd0 : a % b;
    q = sgn && (d1[31] ^ d2[31]) ? -uq : uq;
    r = sgn && d1[31] ? -ur : ur;
`ifdef MD_SCHED_MADD_EN
    madd = (op == OP_MSUB || op == OP_MSUBU)
         ? acc - ((op == OP_MSUB) ? sprod : uprod)
         : acc + ((op == OP_MADD) ? sprod : uprod);
`else
    madd = acc;
`endif
    res = op == OP_MULT  ? sprod :
          op == OP_MULTU ? uprod :
          div_zero       ? acc   :
          is_div(op)     ? {r, q} :
          is_madd(op)    ? madd  : acc;
  end
endmodule

// File: rtl/md_sched.sv
// md_sched: multi-cycle mult/div scheduler holding results for a fixed latency before committing HI/LO
// Define MD_SCHED_MADD_EN to accept madd/maddu/msub/msubu (ops 7-10).
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic        d_md_use,
  output logic        start,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [63:0]     pend, res;
  logic            pend_dz, div_zero, done;
  md_arith u_arith (
    .op(op), .d1(D1), .d2(D2), .hi(HI), .lo(LO), .res(res), .div_zero(div_zero)
  );
  assign start = state == S_IDLE && op_valid && is_muldiv(op);
  assign busy  = state == S_RUN;
  assign stall = d_md_use && (start || busy);
  assign done  = busy && cnt == CW'(1);
  always_comb state_n = start ? S_RUN : done ? S_IDLE : state;
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pend    <= '0;
      pend_dz <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        pend    <= res;
        pend_dz <= div_zero;
        cnt     <= is_div(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (busy) cnt <= cnt - CW'(1);
      if (done && !pend_dz) begin
        HI <= pend[63:32];
        LO <= pend[31:0];
      end else if (state == S_IDLE && op_valid && is_mt(op)) begin
        if (op == OP_MTHI) HI <= D1;
        if (op == OP_MTLO) LO <= D1;
      end
    end
  end
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: vector table, hand sequences and randomized ops against a behavioural HI/LO model
module tb_md_sched;
  import md_pkg::*;
  logic        clk = 1'b0, reset, op_valid, d_md_use;
  logic [3:0]  op;
  logic [31:0] D1, D2, HI, LO;
  logic        start, busy, stall;
  int pass_cnt = 0, total = 0;
  logic [31:0] mhi, mlo;

  md_sched dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .D1(D1), .D2(D2),
    .d_md_use(d_md_use), .start(start), .busy(busy), .stall(stall), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] d1, d2;
    logic        st;
    int          lat;
    logic [31:0] hi, lo;
  } vec_t;
  vec_t vt[10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // architectural effect of one op on the model's HI/LO, with expected accept and latency
  task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic acc, output int lat);
    longint sa, sb;
    logic [63:0] p;
    acc = 1'b0;
    lat = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULT:  begin p = sa * sb; {mhi, mlo} = p; acc = 1'b1; lat = 5; end
      OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; {mhi, mlo} = p; acc = 1'b1; lat = 5; end
      OP_DIV: begin
        acc = 1'b1; lat = 10;
        if (b != 0) begin mlo = 32'(sa / sb); mhi = 32'(sa % sb); end
      end
      OP_DIVU: begin
        acc = 1'b1; lat = 10;
        if (b != 0) begin mlo = a / b; mhi = a % b; end
      end
      OP_MTHI: mhi = a;
      OP_MTLO: mlo = a;
      default: ;
    endcase
  endtask

  // issue one op, return start, busy-cycle count and stall-cycle count
  task automatic apply(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic st, output int lat, output int stc);
    @(negedge clk);
    op_valid = 1'b1; op = o; D1 = a; D2 = b;
    #1;
    st = start;
    stc = stall ? 1 : 0;
    @(posedge clk);
    #1;
    op_valid = 1'b0; op = OP_NOP;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      lat++;
      if (stall) stc++;
    end
  endtask

  initial begin
    logic st, acc, use_d;
    int lat, stc, elat;
    logic [3:0] o;
    logic [31:0] a, b;
    vt[0] = '{OP_MULT,  32'hFFFFFFFA, 32'hFFFFFFFD, 1'b1, 5,  32'h0,        32'h12};
    vt[1] = '{OP_DIV,   32'hFFFFFFF9, 32'h2,        1'b1, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[2] = '{OP_DIVU,  32'h7,        32'h2,        1'b1, 10, 32'h1,        32'h3};
    vt[3] = '{OP_MTHI,  32'h5,        32'h0,        1'b0, 0,  32'h5,        32'h3};
    vt[4] = '{OP_MTLO,  32'h9,        32'h0,        1'b0, 0,  32'h5,        32'h9};
    vt[5] = '{OP_DIVU,  32'h7,        32'h0,        1'b1, 10, 32'h5,        32'h9};
    vt[6] = '{OP_MULTU, 32'hFFFFFFFF, 32'h2,        1'b1, 5,  32'h1,        32'hFFFFFFFE};
    vt[7] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b1, 10, 32'h0,        32'h80000000};
    vt[8] = '{OP_MADD,  32'h1,        32'h1,        1'b0, 0,  32'h0,        32'h80000000};
    vt[9] = '{4'd15,    32'h3,        32'h4,        1'b0, 0,  32'h0,        32'h80000000};
    reset = 1'b1; op_valid = 1'b0; op = OP_NOP; D1 = '0; D2 = '0; d_md_use = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    check("rst_start", start, 0);

    for (int i = 0; i < 10; i++) begin
      apply(vt[i].op, vt[i].d1, vt[i].d2, st, lat, stc);
      check($sformatf("vec%0d_start", i), st, vt[i].st);
      check($sformatf("vec%0d_lat", i), lat, vt[i].lat);
      check($sformatf("vec%0d_hi", i), HI, vt[i].hi);
      check($sformatf("vec%0d_lo", i), LO, vt[i].lo);
    end
    mhi = vt[9].hi;
    mlo = vt[9].lo;

    d_md_use = 1'b1;
    model(OP_MULTU, 32'hFFFFFFFF, 32'h2, acc, elat);
    apply(OP_MULTU, 32'hFFFFFFFF, 32'h2, st, lat, stc);
    check("stall_cycles", stc, 6);
    check("stall_idle", stall, 0);
    check("stall_hi", HI, 32'h1);
    check("stall_lo", LO, 32'hFFFFFFFE);
    d_md_use = 1'b0;

    for (int i = 0; i < 30; i++) begin
      o = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 :
          ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      use_d = 1'($urandom_range(0, 1));
      d_md_use = use_d;
      model(o, a, b, acc, elat);
      apply(o, a, b, st, lat, stc);
      check($sformatf("rnd%0d_op%0d_start", i, o), st, acc);
      check($sformatf("rnd%0d_op%0d_lat", i, o), lat, elat);
      check($sformatf("rnd%0d_op%0d_stall", i, o), stc, use_d ? (acc ? elat + 1 : 0) : 0);
      check($sformatf("rnd%0d_op%0d_hi", i, o), HI, mhi);
      check($sformatf("rnd%0d_op%0d_lo", i, o), LO, mlo);
    end
    d_md_use = 1'b0;

    apply(OP_MTHI, 32'hAA, 32'h0, st, lat, stc);
    check("pre_rst_hi", HI, 32'hAA);
    @(negedge clk);
    op_valid = 1'b1; op = OP_DIV; D1 = 32'd100; D2 = 32'd7;
    @(posedge clk);
    #1 op_valid = 1'b0; op = OP_NOP;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midrun_busy_before_rst", busy, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_hi", HI, 0);
    check("midrun_rst_lo", LO, 0);
    repeat (15) @(negedge clk);
    check("midrun_late_busy", busy, 0);
    check("midrun_late_hi", HI, 0);
    check("midrun_late_lo", LO, 0);

    apply(OP_MTLO, 32'h1234, 32'h0, st, lat, stc);
    check("mtlo_lat", lat, 0);
    check("mtlo_lo", LO, 32'h1234);
    @(negedge clk);
    op_valid = 1'b1; op = OP_MULT; D1 = 32'd2; D2 = 32'd3;
    @(posedge clk);
    #1 op = OP_MTHI; D1 = 32'hDEAD;
    @(negedge clk);
    check("mthi_run_start", start, 0);
    @(posedge clk);
    #1 op_valid = 1'b0; op = OP_NOP;
    check("mthi_run_hi", HI, 0);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    check("mthi_run_done", busy, 0);
    check("mthi_run_final_hi", HI, 0);
    check("mthi_run_final_lo", LO, 32'h6);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
